// File: rtl/execute_pkg.sv
// Shared pipeline types for the execute stage: opcodes, exception flags, E/M bundles.
// EXE_MADD_EN adds the MADD/MADDU/MSUB/MSUBU multiply-accumulate decode.
package execute_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_ADDI, OP_ADDIU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU, OP_LUI,
        OP_TEQ, OP_TNE, OP_TGE, OP_TGEU, OP_TLT, OP_TLTU,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
        OP_SB, OP_SH, OP_SW,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
    } op_t;

    typedef struct packed {
        logic ADEL;
        logic ADES;
        logic SYS;
        logic BP;
        logic RI;
        logic OV;
        logic TR;
    } exc_t;

    typedef struct packed {
        op_t         OP;
        logic [31:0] pc;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [15:0] imm;
        logic [4:0]  regw;
        logic        rm;
        logic        wm;
        exc_t        exp;
        logic        hi_w;
        logic        lo_w;
    } E_type;

    typedef struct packed {
        op_t         OP;
        logic [31:0] pc;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [4:0]  regw;
        logic        rm;
        logic        wm;
        exc_t        exp;
        logic        hi_w;
        logic        lo_w;
    } M_type;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} exe_state_t;

    function automatic logic is_mul_op(op_t op);
`ifdef EXE_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    function automatic logic is_div_op(op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_md(op_t op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_madd_op(op_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/execute_divider.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle; sign handling lives in execute.
module divider #(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    localparam int unsigned PRESHIFT = 32 - DIV_ITERS;
    localparam logic [5:0]  LAST     = 6'(DIV_ITERS - 1);

    logic [31:0] rem, quo, dvs;
    logic [5:0]  cnt;
    logic        run;
    logic [32:0] trial;

    assign trial = {rem, quo[31]} - {1'b0, dvs};
    // done flags the final iteration so the FSM can leave DIV on the same edge
    assign done  = run && (cnt == LAST);
    assign q     = quo;
    assign r     = rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (abort) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= a << PRESHIFT;
            dvs <= b;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            rem <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
            quo <= {quo[30:0], ~trial[32]};
            cnt <= cnt + 6'd1;
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/execute.sv
// MIPS execute stage: single-cycle ALU/AGU/traps, 2-cycle MULT and iterative DIV behind busy.
// Defining EXE_MADD_EN enables MADD/MADDU/MSUB/MSUBU through the multiply path.
module execute
    import execute_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  E_type       E,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic        stall_in,
    input  logic        flush,
    output M_type       M_pre,
    output logic        busy
);

    exe_state_t state, state_nx;

    logic [31:0] va, vb, simm, zimm;
    logic [31:0] add_s, addi_s, sub_s;
    logic [4:0]  shamt;
    logic [31:0] alu, vb_out;
    logic        ov, tr, ri, hw, lw;
    logic        start_mul, start_div, md_signed;

    assign va     = E.valA;
    assign vb     = E.valB;
    assign simm   = {{16{E.imm[15]}}, E.imm};
    assign zimm   = {16'b0, E.imm};
    assign shamt  = E.imm[10:6];
    assign add_s  = va + vb;
    assign addi_s = va + simm;
    assign sub_s  = va - vb;

    assign md_signed = is_signed_md(E.OP);
    assign start_mul = (state == IDLE) && (E.exp == '0) && is_mul_op(E.OP);
    assign start_div = (state == IDLE) && (E.exp == '0) && is_div_op(E.OP);

    always_comb begin
        alu    = va;
        vb_out = vb;
        ov     = 1'b0;
        tr     = 1'b0;
        ri     = 1'b0;
        hw     = E.hi_w;
        lw     = E.lo_w;
        case (E.OP)
            OP_ADD:   begin alu = add_s;  ov = (va[31] == vb[31]) && (add_s[31] != va[31]); end
            OP_ADDI:  begin alu = addi_s; ov = (va[31] == simm[31]) && (addi_s[31] != va[31]); end
            OP_SUB:   begin alu = sub_s;  ov = (va[31] != vb[31]) && (sub_s[31] != va[31]); end
            OP_ADDU:  alu = add_s;
            OP_ADDIU: alu = addi_s;
            OP_SUBU:  alu = sub_s;
            OP_AND:   alu = va & vb;
            OP_OR:    alu = va | vb;
            OP_XOR:   alu = va ^ vb;
            OP_NOR:   alu = ~(va | vb);
            OP_ANDI:  alu = va & zimm;
            OP_ORI:   alu = va | zimm;
            OP_XORI:  alu = va ^ zimm;
            OP_SLL:   alu = vb << shamt;
            OP_SRL:   alu = vb >> shamt;
            OP_SRA:   alu = 32'($signed(vb) >>> shamt);
            OP_SLLV:  alu = vb << va[4:0];
            OP_SRLV:  alu = vb >> va[4:0];
            OP_SRAV:  alu = 32'($signed(vb) >>> va[4:0]);
            OP_SLT:   alu = {31'b0, $signed(va) < $signed(vb)};
            OP_SLTU:  alu = {31'b0, va < vb};
            OP_SLTI:  alu = {31'b0, $signed(va) < $signed(simm)};
            OP_SLTIU: alu = {31'b0, va < simm};
            OP_LUI:   alu = {E.imm, 16'b0};
            OP_TEQ:   tr = (va == vb);
            OP_TNE:   tr = (va != vb);
            OP_TGE:   tr = ($signed(va) >= $signed(vb));
            OP_TGEU:  tr = (va >= vb);
            OP_TLT:   tr = ($signed(va) < $signed(vb));
            OP_TLTU:  tr = (va < vb);
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW:
                      alu = addi_s;
            OP_MFHI:  alu = hi;
            OP_MFLO:  alu = lo;
            OP_MTHI:  begin vb_out = va; hw = 1'b1; end
            OP_MTLO:  lw = 1'b1;
`ifndef EXE_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
                      ri = 1'b1;
`endif
            default:  ;
        endcase
    end

    // multiply datapath: operands latched on accept, product registered in MUL
    logic [31:0] mul_a, mul_b;
    logic        mul_sgn;
    logic [63:0] mul_ea, mul_eb, prod, mul_full, res;
`ifdef EXE_MADD_EN
    logic [63:0] mul_acc;
    logic        mul_sub;
    assign mul_full = mul_sub ? (mul_acc - prod) : (mul_acc + prod);
`else
    assign mul_full = prod;
`endif
    assign mul_ea = mul_sgn ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
    assign mul_eb = mul_sgn ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
    assign prod   = mul_ea * mul_eb;

    logic        res_div, q_neg, r_neg;
    logic        div_done;
    logic [31:0] div_q, div_r, div_a, div_b, done_lo, done_hi;

    assign div_a = (md_signed && va[31]) ? (32'd0 - va) : va;
    assign div_b = (md_signed && vb[31]) ? (32'd0 - vb) : vb;

    divider #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (start_div && !flush),
        .abort  (flush),
        .a      (div_a),
        .b      (div_b),
        .done   (div_done),
        .q      (div_q),
        .r      (div_r)
    );

    assign done_lo = res_div ? (q_neg ? (32'd0 - div_q) : div_q) : res[31:0];
    assign done_hi = res_div ? (r_neg ? (32'd0 - div_r) : div_r) : res[63:32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_sgn <= 1'b0;
            res     <= '0;
            res_div <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
`ifdef EXE_MADD_EN
            mul_acc <= '0;
            mul_sub <= 1'b0;
`endif
        end else begin
            if (start_mul && !flush) begin
                mul_a   <= va;
                mul_b   <= vb;
                mul_sgn <= md_signed;
                res_div <= 1'b0;
`ifdef EXE_MADD_EN
                mul_acc <= is_madd_op(E.OP) ? {hi, lo} : '0;
                mul_sub <= E.OP inside {OP_MSUB, OP_MSUBU};
`endif
            end
            if (start_div && !flush) begin
                q_neg   <= md_signed && (va[31] ^ vb[31]);
                r_neg   <= md_signed && va[31];
                res_div <= 1'b1;
            end
            if (state == MUL)
                res <= mul_full;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        M_pre    = '0;
        case (state)
            IDLE: begin
                if (start_mul) begin
                    state_nx = MUL;
                    busy     = 1'b1;
                end else if (start_div) begin
                    state_nx = DIV;
                    busy     = 1'b1;
                end else begin
                    M_pre.OP   = E.OP;
                    M_pre.pc   = E.pc;
                    M_pre.valA = alu;
                    M_pre.valB = vb_out;
                    M_pre.regw = E.regw;
                    M_pre.rm   = E.rm;
                    M_pre.wm   = E.wm;
                    M_pre.hi_w = hw;
                    M_pre.lo_w = lw;
                    M_pre.exp  = E.exp;
                    if (E.exp == '0) begin
                        M_pre.exp.OV = ov;
                        M_pre.exp.TR = tr;
                        M_pre.exp.RI = ri;
                    end
                end
            end
            MUL: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (div_done)
                    state_nx = DONE;
            end
            DONE: begin
                M_pre.OP   = E.OP;
                M_pre.pc   = E.pc;
                M_pre.valA = done_lo;
                M_pre.valB = done_hi;
                M_pre.regw = E.regw;
                M_pre.rm   = E.rm;
                M_pre.wm   = E.wm;
                M_pre.hi_w = 1'b1;
                M_pre.lo_w = 1'b1;
                if (!stall_in)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // flush overrides every state, including a DONE hold or a same-cycle completion
        if (flush) begin
            state_nx = IDLE;
            busy     = 1'b0;
            M_pre    = '0;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: driver queues expected M bundles, a monitor checks on retire.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] hi = '0;
    logic [31:0] lo = '0;
    E_type       E;
    M_type       M_pre;
    logic        busy;

    int total = 0;
    int bad   = 0;

    M_type sb_q[$];
    string sb_n[$];

    always #5 clk = ~clk;

    execute #(.DIV_ITERS(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .E        (E),
        .hi       (hi),
        .lo       (lo),
        .stall_in (stall_in),
        .flush    (flush),
        .M_pre    (M_pre),
        .busy     (busy)
    );

    function automatic E_type mk_e(op_t op, logic [31:0] pc, logic [31:0] va, logic [31:0] vb,
                                   logic [15:0] imm, logic [4:0] regw, logic rm, logic wm);
        E_type e;
        e      = '0;
        e.OP   = op;
        e.pc   = pc;
        e.valA = va;
        e.valB = vb;
        e.imm  = imm;
        e.regw = regw;
        e.rm   = rm;
        e.wm   = wm;
        return e;
    endfunction

    function automatic M_type mk_m(op_t op, logic [31:0] pc, logic [31:0] va, logic [31:0] vb,
                                   logic [4:0] regw, logic rm, logic wm, exc_t x,
                                   logic hw, logic lw);
        M_type m;
        m      = '0;
        m.OP   = op;
        m.pc   = pc;
        m.valA = va;
        m.valB = vb;
        m.regw = regw;
        m.rm   = rm;
        m.wm   = wm;
        m.exp  = x;
        m.hi_w = hw;
        m.lo_w = lw;
        return m;
    endfunction

    task automatic checkm(string name, M_type act, M_type exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever a non-bubble bundle retires
    initial begin
        M_type zero_m;
        M_type m;
        string n;
        zero_m = '0;
        forever begin
            @(negedge clk);
            if (resetn && !flush) begin
                if (busy) begin
                    checkm("bubble_while_busy", M_pre, zero_m);
                end else if (!stall_in && M_pre !== zero_m) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h expected none", M_pre);
                    end else begin
                        m = sb_q.pop_front();
                        n = sb_n.pop_front();
                        checkm(n, M_pre, m);
                    end
                end
            end
        end
    end

    task automatic issue(string name, E_type e, M_type m, int exp_busy, int holds_req);
        int nb;
        int holds;
        bit ok;
        nb    = 0;
        holds = 0;
        ok    = 1'b0;
        sb_q.push_back(m);
        sb_n.push_back(name);
        E = e;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy && !stall_in) begin
                ok = 1'b1;
                break;
            end
            if (busy) begin
                nb++;
            end else begin
                holds++;
                checkm({name, "_hold"}, M_pre, m);
                if (holds == holds_req) begin
                    @(posedge clk);
                    #1 stall_in = 1'b0;
                end
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: got no retire expected retire within 200 cycles", name);
        end
        checki({name, "_busy_cycles"}, nb, exp_busy);
        @(posedge clk);
        #1 E = '0;
    endtask

    initial begin
        exc_t  x0, xov, xtr, xsys, xbp, xri;
        M_type zero_m;
        E_type e;
        zero_m = '0;
        x0   = '0;
        xov  = '0; xov.OV = 1'b1;
        xtr  = '0; xtr.TR = 1'b1;
        xsys = '0; xsys.SYS = 1'b1;
        xbp  = '0; xbp.BP = 1'b1;
        xri  = '0; xri.RI = 1'b1;
        E = '0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checki("reset_busy", int'(busy), 0);
        checkm("reset_bubble", M_pre, zero_m);
        @(posedge clk);
        #1;

        issue("addi_ov", mk_e(OP_ADDI, 32'h100, 32'h7FFFFFFF, 32'h0, 16'h0001, 5'd5, 1'b0, 1'b0),
              mk_m(OP_ADDI, 32'h100, 32'h80000000, 32'h0, 5'd5, 1'b0, 1'b0, xov, 1'b0, 1'b0), 0, 0);
        issue("addiu", mk_e(OP_ADDIU, 32'h104, 32'h7FFFFFFF, 32'h0, 16'h0001, 5'd5, 1'b0, 1'b0),
              mk_m(OP_ADDIU, 32'h104, 32'h80000000, 32'h0, 5'd5, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("sw_agu", mk_e(OP_SW, 32'h108, 32'h00001000, 32'hDEADBEEF, 16'hFFFC, 5'd0, 1'b0, 1'b1),
              mk_m(OP_SW, 32'h108, 32'h00000FFC, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, x0, 1'b0, 1'b0), 0, 0);
        issue("lw_agu", mk_e(OP_LW, 32'h10C, 32'hFFFFFFF0, 32'h0, 16'h0020, 5'd9, 1'b1, 1'b0),
              mk_m(OP_LW, 32'h10C, 32'h00000010, 32'h0, 5'd9, 1'b1, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("sub_ov", mk_e(OP_SUB, 32'h110, 32'h80000000, 32'h1, 16'h0, 5'd2, 1'b0, 1'b0),
              mk_m(OP_SUB, 32'h110, 32'h7FFFFFFF, 32'h1, 5'd2, 1'b0, 1'b0, xov, 1'b0, 1'b0), 0, 0);
        issue("slt", mk_e(OP_SLT, 32'h114, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd3, 1'b0, 1'b0),
              mk_m(OP_SLT, 32'h114, 32'h1, 32'h1, 5'd3, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("sltu", mk_e(OP_SLTU, 32'h118, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd3, 1'b0, 1'b0),
              mk_m(OP_SLTU, 32'h118, 32'h0, 32'h1, 5'd3, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("sll", mk_e(OP_SLL, 32'h11C, 32'h0, 32'h1, 16'h0100, 5'd4, 1'b0, 1'b0),
              mk_m(OP_SLL, 32'h11C, 32'h10, 32'h1, 5'd4, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("lui", mk_e(OP_LUI, 32'h120, 32'h0, 32'h0, 16'h1234, 5'd6, 1'b0, 1'b0),
              mk_m(OP_LUI, 32'h120, 32'h12340000, 32'h0, 5'd6, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("teq", mk_e(OP_TEQ, 32'h124, 32'h5, 32'h5, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_TEQ, 32'h124, 32'h5, 32'h5, 5'd0, 1'b0, 1'b0, xtr, 1'b0, 1'b0), 0, 0);
        issue("tne", mk_e(OP_TNE, 32'h128, 32'h5, 32'h5, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_TNE, 32'h128, 32'h5, 32'h5, 5'd0, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        hi = 32'h12345678;
        lo = 32'h9ABCDEF0;
        issue("mfhi", mk_e(OP_MFHI, 32'h12C, 32'h0, 32'h0, 16'h0, 5'd7, 1'b0, 1'b0),
              mk_m(OP_MFHI, 32'h12C, 32'h12345678, 32'h0, 5'd7, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);
        issue("mthi", mk_e(OP_MTHI, 32'h130, 32'hCAFE0001, 32'h0, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MTHI, 32'h130, 32'hCAFE0001, 32'hCAFE0001, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b0), 0, 0);

        issue("mult", mk_e(OP_MULT, 32'h200, 32'hFFFFFFFF, 32'h2, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MULT, 32'h200, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 2, 0);
        issue("multu", mk_e(OP_MULTU, 32'h204, 32'hFFFFFFFF, 32'h2, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MULTU, 32'h204, 32'hFFFFFFFE, 32'h1, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 2, 0);
        issue("div_neg", mk_e(OP_DIV, 32'h208, 32'hFFFFFFF9, 32'h2, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_DIV, 32'h208, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 33, 0);
        issue("divu_by0", mk_e(OP_DIVU, 32'h20C, 32'h5, 32'h0, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_DIVU, 32'h20C, 32'hFFFFFFFF, 32'h5, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 33, 0);
        issue("divu_b2b", mk_e(OP_DIVU, 32'h210, 32'd100, 32'd7, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_DIVU, 32'h210, 32'd14, 32'd2, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 33, 0);

        // pre-existing exception: no multicycle start, flags untouched
        e = mk_e(OP_MULT, 32'h214, 32'h3, 32'h4, 16'h0, 5'd0, 1'b0, 1'b0);
        e.exp = xsys;
        issue("mult_exc", e, mk_m(OP_MULT, 32'h214, 32'h3, 32'h4, 5'd0, 1'b0, 1'b0, xsys, 1'b0, 1'b0), 0, 0);
        e = mk_e(OP_ADD, 32'h218, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd8, 1'b0, 1'b0);
        e.exp = xbp;
        issue("add_exc", e, mk_m(OP_ADD, 32'h218, 32'h80000000, 32'h1, 5'd8, 1'b0, 1'b0, xbp, 1'b0, 1'b0), 0, 0);

`ifdef EXE_MADD_EN
        hi = 32'h0;
        lo = 32'd10;
        issue("madd", mk_e(OP_MADD, 32'h21C, 32'd3, 32'd4, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MADD, 32'h21C, 32'd22, 32'h0, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 2, 0);
`else
        issue("madd_ri", mk_e(OP_MADD, 32'h21C, 32'd3, 32'd4, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MADD, 32'h21C, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, xri, 1'b0, 1'b0), 0, 0);
`endif

        // flush a divide in flight at cycle 10, then an ADDU must retire normally
        E = mk_e(OP_DIV, 32'h300, 32'd100, 32'd3, 16'h0, 5'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        checkm("flush_bubble", M_pre, zero_m);
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb_q.push_back(mk_m(OP_ADDU, 32'h304, 32'h00000003, 32'h2, 5'd10, 1'b0, 1'b0, x0, 1'b0, 1'b0));
        sb_n.push_back("addu_after_flush");
        E = mk_e(OP_ADDU, 32'h304, 32'h1, 32'h2, 16'h0, 5'd10, 1'b0, 1'b0);
        @(negedge clk);
        checki("flush_busy", int'(busy), 0);
        @(posedge clk);
        #1 E = '0;

        // DONE held by downstream stall for 3 cycles
        stall_in = 1'b1;
        issue("multu_stall", mk_e(OP_MULTU, 32'h400, 32'd3, 32'd5, 16'h0, 5'd0, 1'b0, 1'b0),
              mk_m(OP_MULTU, 32'h400, 32'd15, 32'h0, 5'd0, 1'b0, 1'b0, x0, 1'b1, 1'b1), 2, 3);
        @(negedge clk);
        checki("idle_after_stall_busy", int'(busy), 0);
        checkm("idle_after_stall_bubble", M_pre, zero_m);
        @(posedge clk);
        #1;
        issue("addu_after_stall", mk_e(OP_ADDU, 32'h404, 32'hFFFFFFFF, 32'h2, 16'h0, 5'd11, 1'b0, 1'b0),
              mk_m(OP_ADDU, 32'h404, 32'h1, 32'h2, 5'd11, 1'b0, 1'b0, x0, 1'b0, 1'b0), 0, 0);

        repeat (2) @(posedge clk);
        checki("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage MIPS pipeline, between the decode/issue register and the memory stage. Computes ALU results, effective addresses, branch-free arithmetic exceptions (OV, TR) and HI/LO results, and produces the `M_type` bundle that the memory stage consumes. Single-cycle ops finish combinationally. MULT/MULTU use a 2-cycle registered multiplier; DIV/DIVU use a 32-iteration radix-2 divider. Both stall upstream through `busy`.

## Interface
- `DIV_ITERS`, default 32: divider iterations, one quotient bit per cycle; legal values are 32 only, parameterised for verification speed-up at 8/16 with reduced operands.
- `clk` in 1: pipeline clock.
- `resetn` in 1: asynchronous, active-low reset.
- `E` in `E_type`: decoded instruction.
  - Fields: `OP`, `pc`, `valA`, `valB`, `imm`, `regw`, `rm`, `wm`, `exp`, `hi_w`, `lo_w`.
  - Held stable by upstream while `busy`=1.
- `hi`, `lo` in 32 each: forwarded HI/LO values, used by MFHI/MFLO and the MADD family.
- `stall_in` in 1: memory stage not ready. Its `pcf3` drives this.
- `flush` in 1: exception or ERET committed downstream. Kills the instruction in E.
- `M_pre` out `M_type`: next-cycle input of the E→M register. Valid only when `busy`=0.
- `busy` out 1: execute cannot retire E this cycle. ORed into the upstream stall.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- In IDLE:
  - Non-multicycle op: `busy`=0 and `M_pre` is computed combinationally from `E`.
  - MULT/MULTU: latch operands, go to MUL, `busy`=1.
  - DIV/DIVU: latch operands and sign flags, start the divider, go to DIV, `busy`=1.
- MUL: one partial-product cycle, then DONE.
- DIV: stay until the divider reports `done` after `DIV_ITERS` cycles, then DONE.
- DONE:
  - `busy`=0; `M_pre` carries the latched result with `hi_w`=`lo_w`=1, `valA`=LO and `valB`=HI.
  - Go to IDLE when `stall_in`=0. Otherwise hold DONE with the result frozen.
- ALU ops: ADD(I)/ADDU/SUB/SUBU/logic/shifts/SLT(U)/LUI, results 32-bit.
  - ADD, ADDI, SUB set `exp.OV` on signed overflow; `regw` is still forwarded and the memory stage squashes it.
- Trap ops (TEQ, TNE, TGE, …) set `exp.TR` when their condition is true.
- Loads and stores:
  - `M_pre.valA` = `E.valA` + sign-extended `imm`, wrapping mod 2^32.
  - `M_pre.valB` = `E.valB`, the store data or the LWL/LWR merge source.
  - `rm`, `wm`, `regw` and `OP` pass through.
- MFHI/MFLO: result is `hi`/`lo`.
- MTHI/MTLO: set `hi_w` or `lo_w`, with the value in `valB` or `valA` respectively.
- Signed divide:
  - Divide magnitudes, then negate the quotient if the signs differ and give the remainder the dividend's sign.
  - Divide by zero, unsigned: quotient 0xFFFFFFFF, remainder = dividend. Signed: same rules applied to the magnitudes, then sign fix-up. No exception.
- `E.exp` bits already set: pass through unchanged, with no multicycle start.
- `flush`:
  - On the next edge the FSM returns to IDLE and the divider aborts.
  - `M_pre` is all-zero in the cycle `flush` is high.
  - Flush beats a DONE hold or a completion in the same cycle.

## Timing
- Reset values: FSM IDLE, operand/result/divider registers 0. `busy`=0 while `E` is a bubble. `M_pre` is the all-zero bubble for an all-zero `E`.
- Single-cycle ops: zero added latency.
- MULT accepted in cycle 0:
  - `busy`=1 in cycles 0 and 1.
  - Cycle 2: DONE, `busy`=0, result on `M_pre`.
- DIV accepted in cycle 0:
  - `busy`=1 in cycles 0 to `DIV_ITERS`.
  - DONE in cycle `DIV_ITERS`+1.
- While `busy`=1, `M_pre` is the bubble.
- An op is consumed at the edge where `busy`=0 and `stall_in`=0.
- Back-to-back DIVs: the second starts the cycle after the first leaves DONE.

## Configuration
- `EXE_MADD_EN` defined:
  - Decodes MADD/MADDU/MSUB/MSUBU through the MUL path.
  - Result = {`hi`,`lo`} ± product, 64-bit wrap.
  - Same 2-cycle latency.
- `EXE_MADD_EN` undefined: those opcodes set `exp.RI`.

## Structure
- Shared pipeline header/package holds:
  - `E_type`/`M_type` and the new `OP_MADD*` opcodes.
  - Exception struct fields.
  - A new `exe_state_t` enum.
- Sub-module `divider`:
  - Inputs: `clk`, `resetn`, `start`, `abort`, `a`, `b`.
  - Outputs: `done`, `q`, `r`.
  - Restoring, unsigned core. Sign handling stays in execute.

## Test plan
- ADDI `valA`=0x7FFFFFFF, `imm`=1 → `exp.OV`=1, `busy`=0. ADDIU with the same operands → `valA`=0x80000000, no OV.
- SW, `valA`=0x1000, `imm`=0xFFFC → `M_pre.valA`=0x0FFC, `wm`=1, `valB`=store data.
- MULT 0xFFFFFFFF × 2, signed:
  - `busy` high 2 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV −7/2:
  - `busy` high 33 cycles.
  - Quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1).
  - DIVU 5/0 → quotient 0xFFFFFFFF, remainder 5.
- DIV in progress with `flush` pulsed at cycle 10 → IDLE next cycle, `busy`=0. A following ADDU completes with the correct result.
- DONE with `stall_in`=1 for 3 cycles → result held stable on `M_pre` and `busy`=0. Then consumed and the FSM returns to IDLE.
